// File: rtl/regfile_pkg.sv
// Shared constants and types for the scoreboarded register file.
package regfile_pkg;

    localparam int DEF_DATA_W   = 64;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_ZERO_REG = 31;
    localparam int DEF_AW       = $clog2(DEF_NUM_REGS);

    // Register address and data types at the default geometry.
    typedef logic [DEF_AW-1:0]     reg_addr_t;
    typedef logic [DEF_DATA_W-1:0] reg_data_t;

endpackage : regfile_pkg

// File: rtl/regfile_rdport.sv
// One combinational read port: address mux, zero-register forcing,
// optional write-to-read forwarding and busy masking.
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int AW       = DEF_AW,
    parameter int ZERO_REG = DEF_ZERO_REG,
    parameter int BYPASS   = 1
) (
    input  logic [AW-1:0]              rd_addr,
    input  logic [NUM_REGS*DATA_W-1:0] reg_flat,
    input  logic [NUM_REGS-1:0]        busy_vec,
    input  logic                       wr_en,
    input  logic [AW-1:0]              wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_busy
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

    logic wr_hit;

    // A write in flight to the address being read this cycle.
    assign wr_hit = wr_en && (wr_addr == rd_addr);

    // Select stored data, forward the writeback when enabled, and force the
    // zero register to read as an idle, all-zero source.
    always_comb begin
        rd_data = reg_flat[int'(rd_addr)*DATA_W +: DATA_W];
        rd_busy = busy_vec[rd_addr];
        if ((BYPASS != 0) && wr_hit) begin
            rd_data = wr_data;
            rd_busy = 1'b0;
        end
        if (rd_addr == ZERO_ADDR) begin
            rd_data = '0;
            rd_busy = 1'b0;
        end
    end

endmodule : regfile_rdport

// File: rtl/regfile_sb.sv
// Multi-port register file with a per-register busy scoreboard.
// Issue marks a destination pending; writeback stores data and clears it.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = DEF_ZERO_REG,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*AW-1:0]     ReadRegister,
    output logic [NUM_RD*DATA_W-1:0] ReadData,
    output logic [NUM_RD-1:0]        ReadBusy,
    input  logic [AW-1:0]            WriteRegister,
    input  logic [DATA_W-1:0]        WriteData,
    input  logic                     RegWrite,
    input  logic                     IssueValid,
    input  logic [AW-1:0]            IssueRegister,
    output logic [NUM_REGS-1:0]      BusyVec
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

    logic [DATA_W-1:0]          regs_reg [NUM_REGS];
    logic [NUM_REGS*DATA_W-1:0] reg_flat;
    logic [NUM_REGS-1:0]        busy_reg;
    logic [NUM_REGS-1:0]        busy_next;
    logic                       wr_accept;
    logic                       wr_live;

    // Writes to the zero register are dropped; it has no storage meaning.
    assign wr_accept = RegWrite && (WriteRegister != ZERO_ADDR);

    // Forwarding and busy masking only apply outside reset so that reads
    // return zero while reset is held.
    assign wr_live = RegWrite && reset;

    // Register storage: async clear, one write port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (wr_accept) begin
            regs_reg[WriteRegister] <= WriteData;
        end
    end

    // Scoreboard next state: writeback clears first, then issue sets, so a
    // same-cycle allocation of the same register wins.
    always_comb begin
        busy_next = busy_reg;
        if (RegWrite) begin
            busy_next[WriteRegister] = 1'b0;
        end
        if (IssueValid && (IssueRegister != ZERO_ADDR)) begin
            busy_next[IssueRegister] = 1'b1;
        end
        busy_next[ZERO_ADDR] = 1'b0;
    end

    // Scoreboard state register with async clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign BusyVec = busy_reg;

    // Flatten the array so each read port sees the full register set.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
            assign reg_flat[gi*DATA_W +: DATA_W] = regs_reg[gi];
        end
    endgenerate

    // Independent read ports.
    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
            regfile_rdport #(
                .DATA_W   (DATA_W),
                .NUM_REGS (NUM_REGS),
                .AW       (AW),
                .ZERO_REG (ZERO_REG),
                .BYPASS   (BYPASS)
            ) u_rdport (
                .rd_addr  (ReadRegister[gi*AW +: AW]),
                .reg_flat (reg_flat),
                .busy_vec (busy_reg),
                .wr_en    (wr_live),
                .wr_addr  (WriteRegister),
                .wr_data  (WriteData),
                .rd_data  (ReadData[gi*DATA_W +: DATA_W]),
                .rd_busy  (ReadBusy[gi])
            );
        end
    endgenerate

endmodule : regfile_sb

// File: tb/tb_regfile_sb.sv
// Directed bench: a default instance (64b, 32 regs, 2 ports, forwarding on)
// and a small instance (32b, 16 regs, 4 ports, forwarding off) driven with
// the same stimulus. Address 31 truncates to 15, the small instance's zero reg.
module tb_regfile_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        we;
    logic        iv;
    logic [4:0]  wa;
    logic [4:0]  ia;
    logic [63:0] wd;
    logic [4:0]  ra [4];

    // Default instance
    logic [9:0]   rr0;
    logic [127:0] rd0;
    logic [1:0]   rb0;
    logic [31:0]  bv0;

    // Small instance
    logic [15:0]  rr1;
    logic [127:0] rd1;
    logic [3:0]   rb1;
    logic [15:0]  bv1;

    assign rr0 = {ra[1], ra[0]};
    assign rr1 = {ra[3][3:0], ra[2][3:0], ra[1][3:0], ra[0][3:0]};

    regfile_sb #(
        .DATA_W(64), .NUM_REGS(32), .NUM_RD(2), .ZERO_REG(31), .BYPASS(1)
    ) dut0 (
        .clk           (clk),
        .reset         (reset),
        .ReadRegister  (rr0),
        .ReadData      (rd0),
        .ReadBusy      (rb0),
        .WriteRegister (wa),
        .WriteData     (wd),
        .RegWrite      (we),
        .IssueValid    (iv),
        .IssueRegister (ia),
        .BusyVec       (bv0)
    );

    regfile_sb #(
        .DATA_W(32), .NUM_REGS(16), .NUM_RD(4), .ZERO_REG(15), .BYPASS(0)
    ) dut1 (
        .clk           (clk),
        .reset         (reset),
        .ReadRegister  (rr1),
        .ReadData      (rd1),
        .ReadBusy      (rb1),
        .WriteRegister (wa[3:0]),
        .WriteData     (wd[31:0]),
        .RegWrite      (we),
        .IssueValid    (iv),
        .IssueRegister (ia[3:0]),
        .BusyVec       (bv1)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] d0(input int p);
        return rd0[p*64 +: 64];
    endfunction

    function automatic logic [63:0] d1(input int p);
        return {32'b0, rd1[p*32 +: 32]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ra(input logic [4:0] a);
        for (int k = 0; k < 4; k++) ra[k] = a;
    endtask

    initial begin
        reset = 1'b0; we = 1'b0; iv = 1'b0;
        wa = '0; ia = '0; wd = '0;
        set_ra(5'd0);
        repeat (2) @(posedge clk);
        #1;

        // Reads stay zero while reset is held, even with a write on the bus
        for (int i = 0; i < 32; i++) begin
            set_ra(5'(i)); wa = 5'(i); we = 1'b1; iv = 1'b1; ia = 5'(i); wd = '1;
            #1;
            chk("rst_rd0_p0", d0(0), 64'h0);
            chk("rst_rd1_p3", d1(3), 64'h0);
            chk("rst_busy0", 64'(rb0), 64'h0);
            chk("rst_busy1", 64'(rb1), 64'h0);
        end
        chk("rst_bv0", 64'(bv0), 64'h0);
        chk("rst_bv1", 64'(bv1), 64'h0);
        we = 1'b0; iv = 1'b0;
        reset = 1'b1;
        tick();

        // All registers read zero after reset on every port
        for (int i = 0; i < 32; i++) begin
            set_ra(5'(i));
            #1;
            chk("init_d0p0", d0(0), 64'h0);
            chk("init_d0p1", d0(1), 64'h0);
            chk("init_d1p0", d1(0), 64'h0);
            chk("init_d1p3", d1(3), 64'h0);
        end
        chk("init_bv0", 64'(bv0), 64'h0);
        chk("init_bv1", 64'(bv1), 64'h0);
        tick();

        // Same-cycle write/read of R5: forwarded vs stored value
        set_ra(5'd5); we = 1'b1; wa = 5'd5; wd = 64'hDEADBEEF_00000001;
        #1;
        chk("byp_d0p0", d0(0), 64'hDEADBEEF_00000001);
        chk("byp_d0p1", d0(1), 64'hDEADBEEF_00000001);
        chk("nobyp_d1p0", d1(0), 64'h0);
        chk("nobyp_d1p1", d1(1), 64'h0);
        tick();
        we = 1'b0;
        #1;
        chk("wr5_d0", d0(0), 64'hDEADBEEF_00000001);
        chk("wr5_d1", d1(0), 64'h00000001);
        chk("wr5_bv0", 64'(bv0), 64'h0);

        // Zero register ignores writes and issues
        set_ra(5'd31); we = 1'b1; wa = 5'd31; wd = '1;
        #1;
        chk("zr_byp_d0", d0(0), 64'h0);
        chk("zr_byp_d1", d1(0), 64'h0);
        tick();
        we = 1'b0; iv = 1'b1; ia = 5'd31;
        #1;
        chk("zr_wr_d0", d0(0), 64'h0);
        chk("zr_wr_d1", d1(0), 64'h0);
        tick();
        iv = 1'b0;
        #1;
        chk("zr_bv0", 64'(bv0), 64'h0);
        chk("zr_bv1", 64'(bv1), 64'h0);
        chk("zr_rb0", 64'(rb0), 64'h0);

        // Issue R7, then write it back while reading it
        iv = 1'b1; ia = 5'd7;
        tick();
        iv = 1'b0; set_ra(5'd7);
        #1;
        chk("iss7_rb0", 64'(rb0[0]), 64'h1);
        chk("iss7_rb1", 64'(rb1[0]), 64'h1);
        chk("iss7_bv0", 64'(bv0), 64'h80);
        chk("iss7_bv1", 64'(bv1), 64'h80);
        we = 1'b1; wa = 5'd7; wd = 64'h01234567_89ABCDEF;
        #1;
        chk("wb7_rb0_masked", 64'(rb0[0]), 64'h0);
        chk("wb7_rb1_unmasked", 64'(rb1[0]), 64'h1);
        chk("wb7_d0", d0(0), 64'h01234567_89ABCDEF);
        chk("wb7_d1", d1(0), 64'h0);
        tick();
        we = 1'b0;
        #1;
        chk("wb7_bv0", 64'(bv0), 64'h0);
        chk("wb7_bv1", 64'(bv1), 64'h0);
        chk("wb7_rb0", 64'(rb0[0]), 64'h0);
        chk("wb7_after_d0", d0(0), 64'h01234567_89ABCDEF);
        chk("wb7_after_d1", d1(0), 64'h89ABCDEF);

        // Issue and writeback of R3 in the same cycle: allocation wins
        iv = 1'b1; ia = 5'd3; we = 1'b1; wa = 5'd3; wd = 64'hA5A5A5A5_5A5A5A5A;
        tick();
        iv = 1'b0; we = 1'b0; ra[1] = 5'd3;
        #1;
        chk("sc3_bv0", 64'(bv0), 64'h8);
        chk("sc3_bv1", 64'(bv1), 64'h8);
        chk("sc3_d0p1", d0(1), 64'hA5A5A5A5_5A5A5A5A);
        chk("sc3_d1p1", d1(1), 64'h5A5A5A5A);
        chk("sc3_rb0p1", 64'(rb0[1]), 64'h1);
        chk("sc3_rb1p1", 64'(rb1[1]), 64'h1);

        // Independent ports with distinct addresses, then shared address
        ra[0] = 5'd5; ra[1] = 5'd7; ra[2] = 5'd3; ra[3] = 5'd31;
        #1;
        chk("ind_d0p0", d0(0), 64'hDEADBEEF_00000001);
        chk("ind_d0p1", d0(1), 64'h01234567_89ABCDEF);
        chk("ind_d1p0", d1(0), 64'h00000001);
        chk("ind_d1p1", d1(1), 64'h89ABCDEF);
        chk("ind_d1p2", d1(2), 64'h5A5A5A5A);
        chk("ind_d1p3", d1(3), 64'h0);
        chk("ind_rb1", 64'(rb1), 64'h4);
        set_ra(5'd7);
        #1;
        chk("same_d1p2", d1(2), 64'h89ABCDEF);
        chk("same_d1p3", d1(3), 64'h89ABCDEF);

        // Allocate R2 and R9 with data, then reset between edges
        we = 1'b1; wa = 5'd2; wd = 64'h11112222_33334444; iv = 1'b1; ia = 5'd2;
        tick();
        wa = 5'd9; wd = 64'h55556666_77778888; ia = 5'd9;
        tick();
        we = 1'b0; iv = 1'b0; ra[0] = 5'd2; ra[1] = 5'd9;
        #1;
        chk("pre_bv0", 64'(bv0), 64'h20C);
        chk("pre_bv1", 64'(bv1), 64'h20C);
        chk("pre_d0p0", d0(0), 64'h11112222_33334444);
        chk("pre_d0p1", d0(1), 64'h55556666_77778888);
        chk("pre_d1p0", d1(0), 64'h33334444);
        chk("pre_d1p1", d1(1), 64'h77778888);
        #1;
        reset = 1'b0; we = 1'b1; wa = 5'd2; wd = 64'hCAFEF00D_CAFEF00D;
        #1;
        chk("midrst_bv0", 64'(bv0), 64'h0);
        chk("midrst_bv1", 64'(bv1), 64'h0);
        chk("midrst_d0p0", d0(0), 64'h0);
        chk("midrst_d0p1", d0(1), 64'h0);
        chk("midrst_d1p0", d1(0), 64'h0);
        chk("midrst_d1p1", d1(1), 64'h0);
        chk("midrst_rb0", 64'(rb0), 64'h0);
        chk("midrst_rb1", 64'(rb1), 64'h0);
        we = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        ra[0] = 5'd5;
        #1;
        chk("post_d0p0", d0(0), 64'h0);
        chk("post_d1p0", d1(0), 64'h0);
        chk("post_bv0", 64'(bv0), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_regfile_sb
